// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: in-order buffer draining to the shared RF write port.
// Optional WB_DIFFTEST_EN adds registered dt_* copies of each retired entry.
module wb_commit_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_rf_we,
    input  logic [AW-1:0]   in_rf_waddr,
    input  logic [XLEN-1:0] in_rf_wdata,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            rf_gnt,
    input  logic [AW-1:0]   fwd_raddr,
    output logic            fwd_hit,
    output logic [XLEN-1:0] fwd_data,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
    output logic [63:0]     instret,
    output logic            wb_busy
`ifdef WB_DIFFTEST_EN
    ,
    output logic            dt_valid,
    output logic [XLEN-1:0] dt_pc,
    output logic            dt_rf_we,
    output logic [AW-1:0]   dt_waddr,
    output logic [XLEN-1:0] dt_wdata
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            we;
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
    } ent_t;

    ent_t             buf_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    cnt_q;

    ent_t head_e;
    logic empty;
    logic full;
    logic push;
    logic pop;

    assign head_e   = buf_q[head_q];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && (!head_e.we || rf_gnt);
    assign wb_busy  = !empty;

    assign rf_we    = !empty && head_e.we;
    assign rf_waddr = empty ? '0 : head_e.waddr;
    assign rf_wdata = empty ? '0 : head_e.wdata;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (vld_q[idx] && buf_q[idx].we &&
                buf_q[idx].waddr == fwd_raddr &&
                fwd_raddr != '0) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_q[idx].wdata;
            end
        end
    end

    // x0 writes are squashed at entry so they retire without a grant.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[tail_q] <= '{
                pc:    in_pc,
                we:    in_rf_we && (in_rf_waddr != '0),
                waddr: in_rf_waddr,
                wdata: in_rf_wdata
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            instret      <= '0;
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
                retire_pc     <= head_e.pc;
            end
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + 1'b1;
            end
            cnt_q        <= cnt_q + CW'(push) - CW'(pop);
            retire_valid <= pop;
            instret      <= instret + 64'(pop);
        end
    end

`ifdef WB_DIFFTEST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dt_valid <= 1'b0;
            dt_pc    <= '0;
            dt_rf_we <= 1'b0;
            dt_waddr <= '0;
            dt_wdata <= '0;
        end else begin
            dt_valid <= pop;
            if (pop) begin
                dt_pc    <= head_e.pc;
                dt_rf_we <= head_e.we;
                dt_waddr <= head_e.waddr;
                dt_wdata <= head_e.wdata;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: per-cycle vector table plus
// hand-written wrap-around and mid-operation reset sequences.
module tb_wb_commit_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic        in_rf_we;
    logic [4:0]  in_rf_waddr;
    logic [63:0] in_rf_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        rf_gnt;
    logic [4:0]  fwd_raddr;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic        retire_valid;
    logic [63:0] retire_pc;
    logic [63:0] instret;
    logic        wb_busy;
`ifdef WB_DIFFTEST_EN
    logic        dt_valid;
    logic [63:0] dt_pc;
    logic        dt_rf_we;
    logic [4:0]  dt_waddr;
    logic [63:0] dt_wdata;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_commit_stage #(.XLEN(64), .DEPTH(4), .AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rf_we     (in_rf_we),
        .in_rf_waddr  (in_rf_waddr),
        .in_rf_wdata  (in_rf_wdata),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_gnt       (rf_gnt),
        .fwd_raddr    (fwd_raddr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .instret      (instret),
        .wb_busy      (wb_busy)
`ifdef WB_DIFFTEST_EN
        ,
        .dt_valid     (dt_valid),
        .dt_pc        (dt_pc),
        .dt_rf_we     (dt_rf_we),
        .dt_waddr     (dt_waddr),
        .dt_wdata     (dt_wdata)
`endif
    );

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        gnt;
        logic [4:0]  fa;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        logic        e_rv;
        logic [63:0] e_rpc;
        logic [63:0] e_ir;
        logic        e_hit;
        logic [63:0] e_fd;
        logic        e_busy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v, input logic [63:0] pc, input logic [4:0] wa,
        input logic [63:0] wd, input logic gnt, input logic [4:0] fa,
        input logic rdy, input logic we, input logic [4:0] ewa,
        input logic [63:0] ewd, input logic rv, input logic [63:0] rpc,
        input logic [63:0] ir, input logic hit, input logic [63:0] fd,
        input logic busy);
        vec_t t;
        t.v = v; t.pc = pc; t.wa = wa; t.wd = wd; t.gnt = gnt; t.fa = fa;
        t.e_rdy = rdy; t.e_we = we; t.e_wa = ewa; t.e_wd = ewd;
        t.e_rv = rv; t.e_rpc = rpc; t.e_ir = ir; t.e_hit = hit;
        t.e_fd = fd; t.e_busy = busy;
        return t;
    endfunction

    vec_t vt [25];

    initial begin
        // idle after reset
        vt[0]  = mk(0, 0, 0, 0, 0, 0,  1,0,0,0, 0,0,0, 0,0, 0);
        // single instruction latency
        vt[1]  = mk(1, 64'h80000000, 5, 64'h1234, 1, 5,
                    1,0,0,0, 0,0,0, 0,0, 0);
        vt[2]  = mk(0, 0, 0, 0, 1, 5,
                    1,1,5,64'h1234, 0,0,0, 1,64'h1234, 1);
        vt[3]  = mk(0, 0, 0, 0, 0, 0,
                    1,0,0,0, 1,64'h80000000,1, 0,0, 0);
        vt[4]  = mk(0, 0, 0, 0, 0, 0,
                    1,0,0,0, 0,64'h80000000,1, 0,0, 0);
        // fill with grant low
        vt[5]  = mk(1, 64'h100, 1, 64'ha1, 0, 3,
                    1,0,0,0, 0,64'h80000000,1, 0,0, 0);
        vt[6]  = mk(1, 64'h104, 2, 64'ha2, 0, 3,
                    1,1,1,64'ha1, 0,64'h80000000,1, 0,0, 1);
        vt[7]  = mk(1, 64'h108, 3, 64'ha3, 0, 3,
                    1,1,1,64'ha1, 0,64'h80000000,1, 0,0, 1);
        vt[8]  = mk(1, 64'h10c, 4, 64'ha4, 0, 3,
                    1,1,1,64'ha1, 0,64'h80000000,1, 1,64'ha3, 1);
        vt[9]  = mk(1, 64'h200, 9, 64'hff, 0, 3,
                    0,1,1,64'ha1, 0,64'h80000000,1, 1,64'ha3, 1);
        // drain
        vt[10] = mk(1, 64'h200, 9, 64'hff, 1, 3,
                    0,1,1,64'ha1, 0,64'h80000000,1, 1,64'ha3, 1);
        vt[11] = mk(0, 0, 0, 0, 1, 3,
                    1,1,2,64'ha2, 1,64'h100,2, 1,64'ha3, 1);
        vt[12] = mk(0, 0, 0, 0, 1, 3,
                    1,1,3,64'ha3, 1,64'h104,3, 1,64'ha3, 1);
        vt[13] = mk(0, 0, 0, 0, 1, 3,
                    1,1,4,64'ha4, 1,64'h108,4, 0,0, 1);
        vt[14] = mk(0, 0, 0, 0, 1, 0,
                    1,0,0,0, 1,64'h10c,5, 0,0, 0);
        // x0 destination
        vt[15] = mk(1, 64'h300, 0, 64'hdead, 0, 0,
                    1,0,0,0, 0,64'h10c,5, 0,0, 0);
        vt[16] = mk(0, 0, 0, 0, 0, 0,
                    1,0,0,64'hdead, 0,64'h10c,5, 0,0, 1);
        vt[17] = mk(0, 0, 0, 0, 0, 0,
                    1,0,0,0, 1,64'h300,6, 0,0, 0);
        // forwarding youngest match
        vt[18] = mk(1, 64'h400, 7, 64'h11, 0, 7,
                    1,0,0,0, 0,64'h300,6, 0,0, 0);
        vt[19] = mk(1, 64'h404, 7, 64'h22, 0, 7,
                    1,1,7,64'h11, 0,64'h300,6, 1,64'h11, 1);
        vt[20] = mk(0, 0, 0, 0, 0, 7,
                    1,1,7,64'h11, 0,64'h300,6, 1,64'h22, 1);
        vt[21] = mk(0, 0, 0, 0, 0, 0,
                    1,1,7,64'h11, 0,64'h300,6, 0,0, 1);
        vt[22] = mk(0, 0, 0, 0, 1, 7,
                    1,1,7,64'h11, 0,64'h300,6, 1,64'h22, 1);
        vt[23] = mk(0, 0, 0, 0, 1, 7,
                    1,1,7,64'h22, 1,64'h400,7, 1,64'h22, 1);
        vt[24] = mk(0, 0, 0, 0, 0, 0,
                    1,0,0,0, 1,64'h404,8, 0,0, 0);

        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_rf_we = 1'b1;
        in_rf_waddr = '0; in_rf_wdata = '0; rf_gnt = 1'b0; fwd_raddr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge clk);
            in_valid = vt[i].v; in_pc = vt[i].pc; in_rf_waddr = vt[i].wa;
            in_rf_wdata = vt[i].wd; rf_gnt = vt[i].gnt;
            fwd_raddr = vt[i].fa;
            #1;
            check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vt[i].e_rdy));
            check($sformatf("v%0d rf_we", i), 64'(rf_we), 64'(vt[i].e_we));
            check($sformatf("v%0d rf_waddr", i), 64'(rf_waddr), 64'(vt[i].e_wa));
            check($sformatf("v%0d rf_wdata", i), rf_wdata, vt[i].e_wd);
            check($sformatf("v%0d retire_valid", i), 64'(retire_valid), 64'(vt[i].e_rv));
            check($sformatf("v%0d retire_pc", i), retire_pc, vt[i].e_rpc);
            check($sformatf("v%0d instret", i), instret, vt[i].e_ir);
            check($sformatf("v%0d fwd_hit", i), 64'(fwd_hit), 64'(vt[i].e_hit));
            check($sformatf("v%0d fwd_data", i), fwd_data, vt[i].e_fd);
            check($sformatf("v%0d wb_busy", i), 64'(wb_busy), 64'(vt[i].e_busy));
        end

        // preload 3 entries, then steady push+pop across pointer wrap
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_pc = 64'h1000 + 64'(4 * i);
            in_rf_waddr = 5'd10; in_rf_wdata = 64'(i);
            rf_gnt = 1'b0; fwd_raddr = '0;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_pc = 64'h1000 + 64'(4 * (k + 3));
            in_rf_waddr = 5'd10; in_rf_wdata = 64'(k + 3); rf_gnt = 1'b1;
            #1;
            check($sformatf("wrap%0d in_ready", k), 64'(in_ready), 64'd1);
            check($sformatf("wrap%0d rf_wdata", k), rf_wdata, 64'(k));
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d retire_valid", k), 64'(retire_valid), 64'd1);
            check($sformatf("wrap%0d retire_pc", k), retire_pc,
                  64'h1000 + 64'(4 * k));
        end
        @(negedge clk);
        in_valid = 1'b0; rf_gnt = 1'b0; fwd_raddr = 5'd10;
        #1;
        check("wrap instret", instret, 64'd18);
        check("wrap busy", 64'(wb_busy), 64'd1);
        check("wrap head data", rf_wdata, 64'd10);
        check("wrap fwd youngest", fwd_data, 64'd12);

        // reset with 3 entries buffered, grant high during reset
        @(negedge clk);
        rst = 1'b1; rf_gnt = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst wb_busy", 64'(wb_busy), 64'd0);
        check("rst instret", instret, 64'd0);
        check("rst rf_we", 64'(rf_we), 64'd0);
        check("rst retire_valid", 64'(retire_valid), 64'd0);
        check("rst retire_pc", retire_pc, 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst fwd_hit", 64'(fwd_hit), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("post-rst%0d retire_valid", k), 64'(retire_valid), 64'd0);
            check($sformatf("post-rst%0d instret", k), instret, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_commit_stage.md
# wb_commit_stage

Parametrised writeback/commit stage for the ysyx pipeline. It accepts completed instructions from MEM over a valid/ready handshake and holds them in a DEPTH-entry in-order buffer. It drains them to a shared register-file write port under an external grant and counts retired instructions. It also exposes a forwarding lookup into pending writes, so ID can bypass results still waiting for the write port.

## Interface
Parameters:
- XLEN, 64, data/PC width
- DEPTH, 4, buffer entries; power of two, ≥2
- AW, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  stage can accept; equals !full
- in_pc  in  XLEN  instruction PC
- in_rf_we  in  1  instruction writes a register
- in_rf_waddr  in  AW  destination register
- in_rf_wdata  in  XLEN  write data
- rf_we  out  1  write request to register file
- rf_waddr  out  AW  write address
- rf_wdata  out  XLEN  write data
- rf_gnt  in  1  register-file port granted this cycle
- fwd_raddr  in  AW  ID source register to look up
- fwd_hit  out  1  a pending buffered write targets fwd_raddr
- fwd_data  out  XLEN  data of the youngest matching pending write
- retire_valid  out  1  one-cycle pulse per retired instruction
- retire_pc  out  XLEN  PC of the retired instruction
- instret  out  64  retired-instruction count
- wb_busy  out  1  buffer non-empty

## Operation
- Circular FIFO with head pointer, tail pointer and count. The count is $clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.
- Push on in_valid && in_ready. An entry stores pc, we, waddr and wdata. When in_rf_waddr==0, we is stored as 0; x0 is never written.
- Head outputs are combinational from the head entry:
  - rf_we = !empty && head.we
  - rf_waddr = head.waddr
  - rf_wdata = head.wdata
  - When empty, rf_waddr and rf_wdata are 0.
- Pop on !empty && (!head.we || rf_gnt). Entries with no write retire without a grant. rf_gnt is ignored while rf_we=0.
- Simultaneous push and pop: both take effect and count is unchanged. in_ready depends only on full, so there is no same-cycle pop-to-push pass-through when full.
- Retire: on each pop, the next cycle has retire_valid=1 and retire_pc=popped pc. instret increments by 1 on each pop, with the new value visible the next cycle. instret wraps at 2^64.
- Forwarding (combinational):
  - A match is a valid entry with we=1 and waddr==fwd_raddr, with fwd_raddr≠0.
  - fwd_hit=1 if any entry matches. fwd_data comes from the youngest match, i.e. the one nearest the tail.
  - The head entry being written this cycle still counts as a hit.
  - With no match, fwd_hit=0 and fwd_data=0.
- Ordering is strictly in-order. No flush input exists; writeback is past the point of no return.

## Timing
- Reset state: count=0, pointers=0, in_ready=1, rf_we=0, retire_valid=0, retire_pc=0, instret=0, wb_busy=0, fwd_hit=0. Reset also clears entry valid state. Reset asserted mid-operation discards all buffered entries without writing them.
- Latency with rf_gnt held high:
  - Push at edge N; rf_we is high in cycle N→N+1.
  - Pop at edge N+1.
  - retire_valid is high in cycle N+1→N+2.
- Full throughput is 1 instruction/cycle with rf_gnt=1.
- With rf_gnt=0 and a writing head, the buffer fills. After DEPTH pushes, in_ready=0 until the first granted pop.
- in_* may change freely while in_ready=0. Only handshake cycles sample in_*.

## Configuration
- WB_DIFFTEST_EN defined: adds outputs dt_valid (1), dt_pc (XLEN), dt_rf_we (1), dt_waddr (AW) and dt_wdata (XLEN). These are registered copies of the popped entry, aligned with retire_valid, and reset to 0.
- WB_DIFFTEST_EN undefined: these ports and registers are absent. All other behaviour is identical.

## Test plan
- Reset, then push pc=0x80000000, we=1, waddr=5, wdata=0x1234 with rf_gnt=1. Required: rf_we=1 with waddr 5 and data 0x1234 the next cycle; retire_valid with retire_pc=0x80000000 the cycle after; instret=1.
- Hold rf_gnt=0 and push DEPTH=4 writing instructions. Required: in_ready=0 after the 4th push and wb_busy=1. Then rf_gnt=1: 4 pops on consecutive cycles, in_ready=1 after the first pop, instret=4.
- Push waddr=0 with we=1, wdata=0xdead, rf_gnt=0. Required: rf_we stays 0, the entry retires without a grant, instret increments.
- Buffer x7=0x11 then x7=0x22 with rf_gnt=0; set fwd_raddr=7. Required: fwd_hit=1, fwd_data=0x22. With fwd_raddr=0: fwd_hit=0.
- Keep count=3 and push+pop every cycle across 10 cycles. Required: pointers wrap, count constant, retire_pc in push order.
- Assert rst with 3 entries buffered. Required: next cycle wb_busy=0, instret=0, rf_we=0; no retire pulse for the discarded entries.
